// File: rtl/alu_pkg.sv
// Shared constants, FSM encoding and helper functions for the inc/dec unit
// built-in self-test.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   // Galois tap mask for x^8+x^6+x^5+x^4+1, shifting right.
   localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

   // Fixed corner vectors run before the pseudo-random part of a run.
   localparam logic [DATA_W-1:0] CORNER_A0   = 8'h00;
   localparam logic              CORNER_SEL0 = 1'b0;
   localparam logic [DATA_W-1:0] CORNER_A1   = 8'hFF;
   localparam logic              CORNER_SEL1 = 1'b1;
   localparam logic [DATA_W-1:0] CORNER_A2   = 8'h7F;
   localparam logic              CORNER_SEL2 = 1'b1;
   localparam logic [DATA_W-1:0] CORNER_A3   = 8'h80;
   localparam logic              CORNER_SEL3 = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_e;

   // Reference model of the unit under test: wraps modulo 2^DATA_W.
   function automatic logic [DATA_W-1:0] incdec_ref(input logic [DATA_W-1:0] a,
                                                    input logic              sel);
      return sel ? (a + 8'd1) : (a - 8'd1);
   endfunction

   // One step of the right-shifting Galois LFSR.
   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/incdec_lfsr.sv
// 8-bit Galois LFSR supplying operands for the random part of a BIST run.
// A zero seed would lock the register at zero, so it is replaced by 8'h01.
module incdec_lfsr
   import alu_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   output logic [DATA_W-1:0] state
);

   localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? 8'h01 : SEED;

   logic [DATA_W-1:0] state_d;
   logic [DATA_W-1:0] state_q;

   // Next LFSR value: reload has priority over stepping.
   always_comb begin
      // NOTE: assigning a default first means no path leaves state_d unassigned, so no latch is inferred.
      state_d = state_q;
      if (load) begin
         state_d = SEED_EFF;
      end else if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   // LFSR register with synchronous reset to the effective seed.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, avoiding simulation races.
      if (!rst_n) begin
         state_q <= SEED_EFF;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/incdec_bist.sv
// Built-in self-test engine for the 8-bit increment/decrement unit. Drives
// operand/mode vectors, checks the returned result against a reference model
// and reports pass/fail, a saturating mismatch count and the first failure.
module incdec_bist
   import alu_pkg::*;
#(
   parameter int unsigned       NUM_VECTORS = 256,
   parameter int unsigned       SETTLE      = 0,
   parameter logic [DATA_W-1:0] SEED        = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [DATA_W-1:0] dut_a,
   output logic              dut_sel,
   input  logic [DATA_W-1:0] dut_b,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [DATA_W-1:0] fail_a,
   output logic              fail_sel,
   output logic [DATA_W-1:0] fail_b
);

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(SETTLE - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic [DATA_W-1:0] dut_a_q, dut_a_d;
   logic              dut_sel_q, dut_sel_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [DATA_W-1:0] fail_a_q, fail_a_d;
   logic              fail_sel_q, fail_sel_d;
   logic [DATA_W-1:0] fail_b_q, fail_b_d;

   logic              lfsr_load;
   logic              lfsr_step;
   logic [DATA_W-1:0] lfsr_state;

   logic [CNT_W-1:0]  vec_idx;
   logic [DATA_W-1:0] vec_a;
   logic              vec_sel;
   logic              vec_rand;
   logic [DATA_W-1:0] exp_b;
   logic [CNT_W-1:0]  err_next;

   incdec_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .state (lfsr_state)
   );

   // Vector about to be loaded: index 0 from IDLE, otherwise the next index.
   always_comb begin
      vec_idx  = (state_q == ST_IDLE) ? '0 : (idx_q + 1'b1);
      vec_a    = lfsr_state;
      vec_sel  = ~vec_idx[0];
      vec_rand = 1'b1;
      case (vec_idx)
         16'd0: begin vec_a = CORNER_A0; vec_sel = CORNER_SEL0; vec_rand = 1'b0; end
         16'd1: begin vec_a = CORNER_A1; vec_sel = CORNER_SEL1; vec_rand = 1'b0; end
         16'd2: begin vec_a = CORNER_A2; vec_sel = CORNER_SEL2; vec_rand = 1'b0; end
         16'd3: begin vec_a = CORNER_A3; vec_sel = CORNER_SEL3; vec_rand = 1'b0; end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_DRIVE;
         ST_DRIVE: state_d = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
         ST_WAIT:  if (wait_q == LAST_WAIT) state_d = ST_CHECK;
         ST_CHECK: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_DRIVE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: vector loading, result checking and status updates.
   always_comb begin
      idx_d       = idx_q;
      wait_d      = wait_q;
      dut_a_d     = dut_a_q;
      dut_sel_d   = dut_sel_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      fail_a_d    = fail_a_q;
      fail_sel_d  = fail_sel_q;
      fail_b_d    = fail_b_q;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      exp_b       = incdec_ref(dut_a_q, dut_sel_q);
      err_next    = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               err_count_d = '0;
               fail_a_d    = '0;
               fail_sel_d  = 1'b0;
               fail_b_d    = '0;
               idx_d       = '0;
               lfsr_load   = 1'b1;
               dut_a_d     = vec_a;
               dut_sel_d   = vec_sel;
            end
         end
         ST_DRIVE: begin
            wait_d = '0;
         end
         ST_WAIT: begin
            wait_d = wait_q + 1'b1;
         end
         ST_CHECK: begin
            if (dut_b != exp_b) begin
               if (err_count_q != '1) begin
                  err_next = err_count_q + 1'b1;
               end
               // A zero count means this is the run's first mismatch.
               if (err_count_q == '0) begin
                  fail_a_d   = dut_a_q;
                  fail_sel_d = dut_sel_q;
                  fail_b_d   = dut_b;
               end
            end
            err_count_d = err_next;
            if (idx_q == LAST_IDX) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_next == '0);
            end else begin
               idx_d     = idx_q + 1'b1;
               dut_a_d   = vec_a;
               dut_sel_d = vec_sel;
               lfsr_step = vec_rand;
            end
         end
         default: ;
      endcase
   end

   // Datapath and status registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q       <= '0;
         wait_q      <= '0;
         dut_a_q     <= '0;
         dut_sel_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         fail_a_q    <= '0;
         fail_sel_q  <= 1'b0;
         fail_b_q    <= '0;
      end else begin
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         dut_a_q     <= dut_a_d;
         dut_sel_q   <= dut_sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         fail_a_q    <= fail_a_d;
         fail_sel_q  <= fail_sel_d;
         fail_b_q    <= fail_b_d;
      end
   end

   assign dut_a     = dut_a_q;
   assign dut_sel   = dut_sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign fail_a    = fail_a_q;
   assign fail_sel  = fail_sel_q;
   assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_incdec_bist.sv
// Directed bench for incdec_bist. Three engines share clock and reset:
// [0] default parameters, [1] NUM_VECTORS=8, [2] NUM_VECTORS=4 with SETTLE=2.
// Each has its own behavioural inc/dec unit. Cycle numbering: the cycle right
// after the edge that accepts start is cycle 1.
module tb_incdec_bist;

   logic        clk;
   logic        rst_n;
   logic [2:0]  start_v;
   logic [7:0]  a_v    [3];
   logic        sel_v  [3];
   logic [7:0]  b_v    [3];
   logic        busy_v [3];
   logic        done_v [3];
   logic        pass_v [3];
   logic [15:0] err_v  [3];
   logic [7:0]  fa_v   [3];
   logic        fs_v   [3];
   logic [7:0]  fb_v   [3];

   int          compared = 0;
   int          mismatched = 0;
   int          cur = 0;
   int          cyc = 0;
   bit          mode0 = 1'b0;
   logic [7:0]  exp_a   [256];
   logic        exp_sel [256];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   incdec_bist u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .dut_a(a_v[0]), .dut_sel(sel_v[0]), .dut_b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
      .fail_a(fa_v[0]), .fail_sel(fs_v[0]), .fail_b(fb_v[0])
   );

   incdec_bist #(.NUM_VECTORS(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .dut_a(a_v[1]), .dut_sel(sel_v[1]), .dut_b(b_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
      .fail_a(fa_v[1]), .fail_sel(fs_v[1]), .fail_b(fb_v[1])
   );

   incdec_bist #(.NUM_VECTORS(4), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .dut_a(a_v[2]), .dut_sel(sel_v[2]), .dut_b(b_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
      .fail_a(fa_v[2]), .fail_sel(fs_v[2]), .fail_b(fb_v[2])
   );

   function automatic logic [7:0] ref_b(input logic [7:0] a, input logic sel);
      logic [7:0] r;
      if (sel) r = a + 8'd1;
      else     r = a - 8'd1;
      return r;
   endfunction

   // Behavioural units: [0] correct, or wrong only for FF/inc when mode0 is set;
   // [1] always returns the inverted result; [2] is only correct in the CHECK
   // cycle of each vector (cycle 4k+4), so early sampling is caught.
   always_comb begin
      b_v[0] = (mode0 && a_v[0] == 8'hFF && sel_v[0]) ? 8'h01 : ref_b(a_v[0], sel_v[0]);
      b_v[1] = ~ref_b(a_v[1], sel_v[1]);
      b_v[2] = (cyc % 4 == 0) ? ref_b(a_v[2], sel_v[2]) : ~ref_b(a_v[2], sel_v[2]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start on engine k; returns just after the accepting edge (cycle 1).
   task automatic pulse_start(input int k);
      @(posedge clk); #1;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      cyc = 1;
   endtask

   // Follow a run of engine cur: check each vector in its DRIVE cycle, note the
   // cycle done is seen and count done cycles; optionally keep start high
   // through the run and the DONE cycle. Runs until 3 cycles past done or budget.
   task automatic run_wait(input int budget, input int period, input int nvec, input bit hold,
                           output int done_cyc, output int pulses, output int seq_bad);
      done_cyc = 0;
      pulses   = 0;
      seq_bad  = 0;
      while (cyc <= budget && (done_cyc == 0 || cyc <= done_cyc + 3)) begin
         if (cyc % period == 1 && (cyc - 1) / period < nvec) begin
            if (a_v[cur] !== exp_a[(cyc - 1) / period] ||
                sel_v[cur] !== exp_sel[(cyc - 1) / period]) seq_bad++;
         end
         if (done_v[cur] === 1'b1) begin
            pulses++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         start_v[cur] = hold && (done_cyc == 0 || cyc <= done_cyc);
         @(posedge clk); #1;
         cyc++;
      end
      start_v[cur] = 1'b0;
   endtask

   initial begin
      logic [7:0] s;
      int         dc, dp, sb, exp_err, seen;

      // Expected vector list, built from the defining sequence.
      exp_a[0] = 8'h00; exp_sel[0] = 1'b0;
      exp_a[1] = 8'hFF; exp_sel[1] = 1'b1;
      exp_a[2] = 8'h7F; exp_sel[2] = 1'b1;
      exp_a[3] = 8'h80; exp_sel[3] = 1'b0;
      s = 8'hA5;
      for (int k = 4; k < 256; k++) begin
         exp_a[k]   = s;
         exp_sel[k] = (k % 2 == 0);
         s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      end

      rst_n   = 1'b0;
      start_v = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_v[0], 1'b0);
      check("rst_done", done_v[0], 1'b0);
      check("rst_pass", pass_v[0], 1'b0);
      check("rst_err", err_v[0], 16'h0000);
      check("rst_a_sel", {a_v[0], sel_v[0]}, 9'h000);
      check("rst_fail", {fa_v[0], fs_v[0], fb_v[0]}, 17'h00000);
      rst_n = 1'b1;

      // Correct unit, default parameters.
      cur = 0;
      pulse_start(0);
      check("t1_busy_c1", busy_v[0], 1'b1);
      run_wait(700, 2, 256, 1'b0, dc, dp, sb);
      check("t1_done_cyc", dc, 513);
      check("t1_pulses", dp, 1);
      check("t1_seq", sb, 0);
      check("t1_pass", pass_v[0], 1'b1);
      check("t1_err", err_v[0], 16'h0000);
      check("t1_fail", {fa_v[0], fs_v[0], fb_v[0]}, 17'h00000);
      check("t1_busy_end", busy_v[0], 1'b0);

      // Unit wrong only for FF/inc: any random FF/inc vector also fails.
      exp_err = 0;
      for (int k = 0; k < 256; k++) if (exp_a[k] == 8'hFF && exp_sel[k]) exp_err++;
      mode0 = 1'b1;
      pulse_start(0);
      run_wait(700, 2, 256, 1'b0, dc, dp, sb);
      check("t2_done_cyc", dc, 513);
      check("t2_pass", pass_v[0], 1'b0);
      check("t2_err", err_v[0], exp_err);
      check("t2_fail_a", fa_v[0], 8'hFF);
      check("t2_fail_sel", fs_v[0], 1'b1);
      check("t2_fail_b", fb_v[0], 8'h01);
      mode0 = 1'b0;

      // Unit inverting every result, 8 vectors.
      cur = 1;
      pulse_start(1);
      run_wait(100, 2, 8, 1'b0, dc, dp, sb);
      check("t3_done_cyc", dc, 17);
      check("t3_err", err_v[1], 16'd8);
      check("t3_pass", pass_v[1], 1'b0);
      check("t3_fail", {fa_v[1], fs_v[1], fb_v[1]}, 17'h00000);

      // SETTLE=2, 4 vectors, unit only correct in the CHECK cycle.
      cur = 2;
      pulse_start(2);
      run_wait(100, 4, 4, 1'b0, dc, dp, sb);
      check("t4_done_cyc", dc, 17);
      check("t4_seq", sb, 0);
      check("t4_pass", pass_v[2], 1'b1);
      check("t4_err", err_v[2], 16'h0000);

      // Reset during vector 100, then a fresh run.
      cur = 0;
      pulse_start(0);
      repeat (200) begin
         @(posedge clk); #1;
      end
      check("t5_vec100_a", a_v[0], exp_a[100]);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("t5_abort_busy", busy_v[0], 1'b0);
      check("t5_abort_a", a_v[0], 8'h00);
      seen = 0;
      repeat (600) begin
         if (done_v[0] === 1'b1) seen++;
         @(posedge clk); #1;
      end
      check("t5_no_done", seen, 0);
      pulse_start(0);
      run_wait(700, 2, 256, 1'b0, dc, dp, sb);
      check("t5_done_cyc", dc, 513);
      check("t5_seq", sb, 0);
      check("t5_pass", pass_v[0], 1'b1);

      // start held high through the run and the DONE cycle.
      pulse_start(0);
      run_wait(700, 2, 256, 1'b1, dc, dp, sb);
      check("t6_done_cyc", dc, 513);
      check("t6_pulses", dp, 1);
      check("t6_busy_end", busy_v[0], 1'b0);
      check("t6_pass", pass_v[0], 1'b1);

      // start in the same cycle as reset: reset wins.
      @(posedge clk); #1;
      rst_n      = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      start_v[0] = 1'b0;
      check("t7_busy", busy_v[0], 1'b0);
      @(posedge clk); #1;
      check("t7_busy_later", busy_v[0], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
